// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length helper for the bus arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ST_PARK,
        ST_OWN,
        ST_BURST,
        ST_LOCK
    } arb_state_t;

    // Undefined-length INCR counts as one beat so it never holds the grant.
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: searches req starting one above ptr, returns a one-hot winner.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);
    logic [PW-1:0] idx;

    // NOTE: every output gets a default before the loop so no path leaves a latch behind.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: registered one-hot hgrant, address-phase owner on hmaster, burst/lock protection.
// Define AHB_ARB_FIXED_PRIO_EN to make the lowest-index requester win instead of round robin.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hreset_n,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);
    localparam logic [NUM_MASTERS-1:0] PARK_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state, state_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt, pick_grant;
    logic                   pick_valid, lock_hold, lock_freeze, burst_hold;
    logic [MW-1:0]          gidx, ptr;
    logic [3:0]             beat_cnt, cnt_nxt;

    rr_priority_picker #(.N(NUM_MASTERS), .PW(MW)) u_picker (
        .req   (hbusreq),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

`ifdef AHB_ARB_FIXED_PRIO_EN
    // Search always starts just above the top index, i.e. at master 0.
    assign ptr = MW'(NUM_MASTERS - 1);
`else
    logic [MW-1:0] rr_ptr, pick_idx;

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (pick_grant[i]) pick_idx = MW'(i);
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n)                          rr_ptr <= MW'(DEFAULT_MASTER);
        else if (hready && state_nxt == ST_OWN) rr_ptr <= pick_idx;
    end

    assign ptr = rr_ptr;
`endif

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (hgrant[i]) gidx = MW'(i);
    end

    always_comb begin
        cnt_nxt = beat_cnt;
        if (htrans == HTRANS_NONSEQ)                     cnt_nxt = 4'(burst_beats(hburst) - 5'd1);
        else if (htrans == HTRANS_SEQ && beat_cnt != '0) cnt_nxt = beat_cnt - 4'd1;

        // lock_hold keeps the grant frozen for one extra hready cycle after hlock falls.
        lock_freeze = hlock[gidx] || lock_hold;
        // Release on the beat that leaves one remaining, so the new grant lines up with the last beat.
        burst_hold  = (cnt_nxt > 4'd1) &&
                      (htrans == HTRANS_NONSEQ || state == ST_BURST || state == ST_LOCK);

        state_nxt = state;
        grant_nxt = hgrant;
        if (lock_freeze) begin
            state_nxt = ST_LOCK;
        end else if (burst_hold) begin
            state_nxt = ST_BURST;
        end else if (pick_valid) begin
            state_nxt = ST_OWN;
            grant_nxt = pick_grant;
        end else begin
            state_nxt = ST_PARK;
            grant_nxt = PARK_GRANT;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state     <= ST_PARK;
            hgrant    <= PARK_GRANT;
            hmaster   <= MW'(DEFAULT_MASTER);
            hmastlock <= 1'b0;
            beat_cnt  <= '0;
            lock_hold <= 1'b0;
        end else if (hready) begin
            state     <= state_nxt;
            hgrant    <= grant_nxt;
            hmaster   <= gidx;
            hmastlock <= hlock[gidx];
            beat_cnt  <= cnt_nxt;
            lock_hold <= hlock[gidx];
        end
    end

    a_grant_onehot: assert property (@(posedge hclk) disable iff (!hreset_n) $onehot(hgrant));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: directed vectors, a cycle-level reference model and literal spot values.
// Builds for either arbitration mode (AHB_ARB_FIXED_PRIO_EN defined or not).
module tb_ahb_bus_arbiter;

    localparam int NM  = 4;
    localparam int DEF = 0;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR8  = 3'd5;

    logic          hclk = 1'b0;
    logic          hreset_n = 1'b0;
    logic [NM-1:0] hbusreq = '0;
    logic [NM-1:0] hlock = '0;
    logic [1:0]    htrans = T_IDLE;
    logic [2:0]    hburst = B_SINGLE;
    logic          hready = 1'b1;
    logic [NM-1:0] hgrant;
    logic [1:0]    hmaster;
    logic          hmastlock;

    int checks = 0;
    int errors = 0;

    // Reference model state: granted master, address-phase owner, lock flag, beats left.
    int m_gnt = DEF;
    int m_mst = DEF;
    bit m_lock = 1'b0;
    int m_rem = 0;
    int m_ptr = DEF;
    bit m_lock_prev = 1'b0;
    bit m_frozen = 1'b0;

    ahb_bus_arbiter #(.NUM_MASTERS(NM), .DEFAULT_MASTER(DEF)) dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_gnt = DEF; m_mst = DEF; m_lock = 1'b0; m_rem = 0;
        m_ptr = DEF; m_lock_prev = 1'b0; m_frozen = 1'b0;
    endtask

    task automatic model_step();
        int  own = m_gnt;
        int  win = -1;
        bit  lock_now = hlock[own];
        bit  protect;
        m_mst  = own;
        m_lock = lock_now;
        if (htrans == T_NONSEQ)               m_rem = burst_len(hburst) - 1;
        else if (htrans == T_SEQ && m_rem > 0) m_rem = m_rem - 1;
        protect = lock_now || m_lock_prev || (m_rem > 1 && (htrans == T_NONSEQ || m_frozen));
        if (!protect) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
            for (int c = NM - 1; c >= 0; c--)
                if (hbusreq[c]) win = c;
`else
            for (int k = NM; k >= 1; k--)
                if (hbusreq[(m_ptr + k) % NM]) win = (m_ptr + k) % NM;
            if (win >= 0) m_ptr = win;
`endif
            m_gnt = (win >= 0) ? win : DEF;
        end
        m_frozen    = protect;
        m_lock_prev = lock_now;
    endtask

    initial forever begin
        @(posedge hclk or negedge hreset_n);
        if (!hreset_n)   model_reset();
        else if (hready) model_step();
        #1;
        check("model hgrant",    32'(hgrant),    32'(1) << m_gnt);
        check("model hmaster",   32'(hmaster),   32'(m_mst));
        check("model hmastlock", 32'(hmastlock), 32'(m_lock));
    end

    task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy);
        hbusreq = req; hlock = lk; htrans = tr; hburst = bu; hready = rdy;
        @(negedge hclk);
    endtask

    initial begin
        repeat (2) @(negedge hclk);
        check("reset hgrant",    32'(hgrant),    32'h1);
        check("reset hmaster",   32'(hmaster),   32'h0);
        check("reset hmastlock", 32'(hmastlock), 32'h0);
        hreset_n = 1'b1;
        step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        check("park idle", 32'(hgrant), 32'h1);

`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
            check("fixed 1010 wins m1", 32'(hgrant), 32'h2);
        end
        step(4'b1000, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        check("fixed only m3", 32'(hgrant), 32'h8);
        step(4'b1010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        check("fixed m1 preempts m3", 32'(hgrant), 32'h2);
        step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        check("fixed park", 32'(hgrant), 32'h1);
`else
        // Alternating SINGLE transfers between masters 1 and 2.
        step(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        check("rr g1", 32'(hgrant), 32'h2);
        check("rr m1", 32'(hmaster), 32'h0);
        step(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        check("rr g2", 32'(hgrant), 32'h4);
        check("rr m2", 32'(hmaster), 32'h1);
        step(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        check("rr g3", 32'(hgrant), 32'h2);
        check("rr m3", 32'(hmaster), 32'h2);
        step(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        check("rr g4", 32'(hgrant), 32'h4);
        step(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        check("rr g5", 32'(hgrant), 32'h2);

        // INCR4 from master 1 with master 2 waiting, hready low twice mid-burst.
        step(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        check("burst setup g", 32'(hgrant), 32'h2);
        check("burst setup m", 32'(hmaster), 32'h1);
        step(4'b0110, 4'b0000, T_NONSEQ, B_INCR4, 1'b1);
        check("burst beat1", 32'(hgrant), 32'h2);
        step(4'b0110, 4'b0000, T_SEQ, B_INCR4, 1'b1);
        check("burst beat2", 32'(hgrant), 32'h2);
        step(4'b0110, 4'b0000, T_SEQ, B_INCR4, 1'b0);
        check("burst wait1", 32'(hgrant), 32'h2);
        step(4'b0110, 4'b0000, T_SEQ, B_INCR4, 1'b0);
        check("burst wait2", 32'(hgrant), 32'h2);
        step(4'b0110, 4'b0000, T_SEQ, B_INCR4, 1'b1);
        check("burst handover g", 32'(hgrant), 32'h4);
        check("burst handover m", 32'(hmaster), 32'h1);
        step(4'b0100, 4'b0000, T_SEQ, B_INCR4, 1'b1);
        check("burst last m", 32'(hmaster), 32'h2);

        // Master 3 locked for three transfers while master 0 requests.
        step(4'b1000, 4'b1000, T_IDLE, B_SINGLE, 1'b1);
        check("lock grant m3", 32'(hgrant), 32'h8);
        step(4'b1001, 4'b1000, T_IDLE, B_SINGLE, 1'b1);
        check("lock held g", 32'(hgrant), 32'h8);
        check("lock hmastlock", 32'(hmastlock), 32'h1);
        step(4'b1001, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1);
        step(4'b1001, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1);
        check("lock held g2", 32'(hgrant), 32'h8);
        step(4'b1001, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        check("lock extra cycle g", 32'(hgrant), 32'h8);
        check("lock released flag", 32'(hmastlock), 32'h0);
        step(4'b1001, 4'b0000, T_IDLE, B_SINGLE, 1'b0);
        check("lock hready low", 32'(hgrant), 32'h8);
        step(4'b1001, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        check("lock handover", 32'(hgrant), 32'h1);

        // Requests drop while owned: park; lone requester keeps its grant.
        step(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        check("own m2", 32'(hgrant), 32'h4);
        step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        check("drop park g", 32'(hgrant), 32'h1);
        check("drop park m", 32'(hmaster), 32'h2);
        step(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        step(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        check("keep lone owner", 32'(hgrant), 32'h4);

        // Asynchronous reset in the middle of an INCR8 burst.
        step(4'b0110, 4'b0000, T_NONSEQ, B_INCR8, 1'b1);
        step(4'b0110, 4'b0000, T_SEQ, B_INCR8, 1'b1);
        check("incr8 frozen", 32'(hgrant), 32'h4);
        #2 hreset_n = 1'b0;
        #1;
        check("async rst hgrant",    32'(hgrant),    32'h1);
        check("async rst hmaster",   32'(hmaster),   32'h0);
        check("async rst hmastlock", 32'(hmastlock), 32'h0);
        @(negedge hclk);
        hreset_n = 1'b1;
        step(4'b0110, 4'b0000, T_SEQ, B_INCR8, 1'b1);
        check("post rst no burst", 32'(hgrant), 32'h2);
`endif

        step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        step(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        check("final park", 32'(hgrant), 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
